// File: rtl/booth_mult_seq_pkg.sv
// Shared definitions for the iterative radix-4 Booth multiplier.
// BOOTH_UNSIGNED_EN widens the digit count so zero-extended operands fit.
package booth_mult_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Booth triple {b[2k+1], b[2k], b[2k-1]} and its neg/one/two control word
  localparam int unsigned DigTripleW = 3;
  localparam int unsigned DigCtlW    = 3;

  function automatic int unsigned booth_ndig(input int unsigned w);
`ifdef BOOTH_UNSIGNED_EN
    return w / 2 + 1;
`else
    return (w + 1) / 2;
`endif
  endfunction

endpackage

// File: rtl/booth_mult_seq_digit_enc.sv
// Radix-4 Booth digit encoder: one triple of the multiplier in, neg/one/two controls out.
// Codes 000 and 111 give a zero digit (no one, no two, no neg).
module booth_digit_enc
  import booth_mult_seq_pkg::*;
(
  input  logic [DigTripleW-1:0] triple,
  output logic                  neg,
  output logic                  one,
  output logic                  two
);

  logic b2, b1, b0;

  assign {b2, b1, b0} = triple;

  assign neg = b2 & ~(b1 & b0);
  assign two = (~b2 & b1 & b0) | (b2 & ~b1 & ~b0);
  assign one = b1 ^ b0;

endmodule

// File: rtl/booth_mult_seq.sv
// Iterative radix-4 Booth multiplier, one digit per clock, valid/ready on both sides.
// Optional BOOTH_UNSIGNED_EN adds is_signed to select unsigned operands.
module booth_mult_seq
  import booth_mult_seq_pkg::*;
#(
  parameter int unsigned W = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
`ifdef BOOTH_UNSIGNED_EN
  input  logic           is_signed,
`endif
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] p,
  output logic           busy
);

  localparam int unsigned NDIG = booth_ndig(W);
  localparam int unsigned BW   = 2 * NDIG;
  localparam int unsigned PW   = 2 * W;
  localparam int unsigned KW   = $clog2(NDIG);

  state_e state_q, state_d;

  logic [PW-1:0] a_q, acc_q, acc_d, p_q;
  logic [BW:0]   b_q;
  logic [KW-1:0] k_q;

  logic          sgn, accept, last_dig;
  logic [PW-1:0] a_ext, sel, mag;
  logic [BW:0]   b_ext;
  logic          dig_neg, dig_one, dig_two;

`ifdef BOOTH_UNSIGNED_EN
  assign sgn = is_signed;
`else
  assign sgn = 1'b1;
`endif

  // Extend by the (gated) sign bit, then resize to the digit-aligned width
  assign a_ext = PW'(signed'({sgn & a[W-1], a}));
  assign b_ext = {BW'(signed'({sgn & b[W-1], b})), 1'b0};

  assign accept   = in_valid && (state_q == S_IDLE);
  assign last_dig = (k_q == KW'(NDIG - 1));

  booth_digit_enc u_enc (
    .triple (b_q[2:0]),
    .neg    (dig_neg),
    .one    (dig_one),
    .two    (dig_two)
  );

  // a_q already carries the 2k shift; negation is one's complement plus carry-in
  always_comb begin
    sel   = dig_two ? {a_q[PW-2:0], 1'b0} : a_q;
    mag   = (dig_one | dig_two) ? sel : '0;
    acc_d = acc_q + (mag ^ {PW{dig_neg}}) + PW'(dig_neg);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_valid) state_d = S_BUSY;
      S_BUSY:  if (last_dig) state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == S_IDLE);
    busy      = (state_q == S_BUSY);
    out_valid = (state_q == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      k_q   <= '0;
      p_q   <= '0;
    end else if (accept) begin
      a_q   <= a_ext;
      b_q   <= b_ext;
      acc_q <= '0;
      k_q   <= '0;
    end else if (state_q == S_BUSY) begin
      a_q   <= a_q << 2;
      b_q   <= b_q >> 2;
      acc_q <= acc_d;
      if (last_dig) begin
        p_q <= acc_d;
      end else begin
        k_q <= k_q + 1'b1;
      end
    end
  end

  assign p = p_q;

endmodule
